// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling off a clock-cycle bit counter.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx #(
  parameter int unsigned CLK_VALUE    = 100_000,
  parameter int unsigned BAUD         = 9600,
  parameter int unsigned CLKS_PER_BIT = CLK_VALUE / BAUD,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(HALF_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

`ifdef UART_RX_PARITY_EN
  localparam state_e StAfterData = StParity;
`else
  localparam state_e StAfterData = StStop;
`endif

  state_e               state_q, state_d;
  logic                 s1_q, s2_q, prev_q;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 pbit_q, pbit_d;
  logic                 perr_q, perr_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      s1_q    <= rx;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pbit_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      pbit_q <= pbit_d;
      perr_q <= perr_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    pbit_d  = pbit_q;
    perr_d  = perr_q;
`endif
    unique case (state_q)
      StIdle: begin
        // Falling edge only, so a line stuck low cannot retrigger.
        if (!s2_q && prev_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = s2_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          shift_d = {s2_q, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + IdxW'(1);
          if (idx_q == IdxLast) state_d = StAfterData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          pbit_d  = s2_q;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif
      StStop: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          data_d  = shift_q;
          ferr_d  = ~s2_q;
          done_d  = 1'b1;
          state_d = StIdle;
`ifdef UART_RX_PARITY_EN
          perr_d  = (^shift_q) ^ pbit_q;
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign rx_data   = data_q;
  assign rx_done   = done_q;
  assign rx_busy   = (state_q != StIdle);
  assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx: a driver serialises frames and queues the expected
// byte, flags and completion cycle; a monitor checks every rx_done against that queue.
module tb_uart_rx;

  localparam int Bit = 10;
`ifdef UART_RX_PARITY_EN
  localparam int Par = 1;
`else
  localparam int Par = 0;
`endif
  // Edge that drove rx low, then E0, start mid at E7, 8+Par full bits, stop mid.
  localparam int DoneLat = 1 + 7 + Bit * (8 + Par) + Bit;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done, rx_busy, frame_err, parity_err;

  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  exp_t sb[$];
  logic [9:0] hold = '0;

  uart_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Monitor: runs on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold = '0;
    end else if (rx_done) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_done: rx_done with empty scoreboard, rx_data=0x%0h (cycle %0d)",
                 rx_data, cyc);
      end else begin
        n_pass++;
        e = sb.pop_front();
        check("rx_data", int'(rx_data), int'(e.data));
        check("frame_err", int'(frame_err), int'(e.ferr));
        check("parity_err", int'(parity_err), int'(e.perr));
        check("done_cycle", cyc, e.cyc);
        hold = {e.data, e.ferr, e.perr};
      end
    end else begin
      check("outputs_hold", int'({rx_data, frame_err, parity_err}), int'(hold));
    end
  end

  task automatic wait_bits(input int n);
    repeat (n * Bit) @(negedge clk);
  endtask

  // Starts and ends on a falling clock edge; rx is left at the stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbit);
    exp_t e;
    e.data = d;
    e.ferr = ~stop;
    e.perr = Par ? ((^d) ^ pbit) : 1'b0;
    e.cyc  = cyc + DoneLat;
    sb.push_back(e);
    rx = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_bits(1);
    end
    if (Par != 0) begin
      rx = pbit;
      wait_bits(1);
    end
    rx = stop;
    wait_bits(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"}, int'(rx_data), 0);
    check({tag, "_rx_done"}, int'(rx_done), 0);
    check({tag, "_rx_busy"}, int'(rx_busy), 0);
    check({tag, "_frame_err"}, int'(frame_err), 0);
    check({tag, "_parity_err"}, int'(parity_err), 0);
  endtask

  initial begin
    logic [7:0] d;
    logic       stop;
    #1 rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_busy", int'(rx_busy), 0);
    end

    send_frame(8'hA5, 1'b1, 1'b0);
    wait_bits(2);

    // Back-to-back: no idle gap between the two frames.
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    wait_bits(2);

    // Short glitch must abort in START.
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_busy", int'(rx_busy), 0);
    check("glitch_rx_data", int'(rx_data), 8'hFF);

    // Framing error, then line held low: no second frame may appear.
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    check("held_low_busy", int'(rx_busy), 0);
    rx = 1'b1;
    wait_bits(2);

    // Reset asserted around the bit-4 sample of a partial frame.
    d  = 8'h5A;
    rx = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      wait_bits(1);
    end
    rx = d[4];
    repeat (7) @(negedge clk);
    #3 rst_n = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    check_reset_outputs("midframe_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_bits(1);
    send_frame(8'h5A, 1'b1, 1'b1);
    wait_bits(2);

    for (int n = 0; n < 12; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(d, stop, 1'($urandom));
      if (!stop) begin
        repeat (40) @(negedge clk);
        rx = 1'b1;
        wait_bits(1);
      end else begin
        repeat ($urandom_range(0, 15)) @(negedge clk);
      end
    end

    wait_bits(3);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
